// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot mux register.
//   clog2     : ceiling log2, used to size the channel index
//   ERR_CNT_W : width of the saturating rejected-select counter
//   out_state_e : output-register occupancy (EMPTY / FULL)
package onehot_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with legality check.
//   sel_i       : N-bit select, expected one-hot
//   index_o     : encoded index (MSB_FIRST=1: bit N-1 -> 0; else bit 0 -> 0)
//   onehot_ok_o : high when exactly one bit of sel_i is set
module onehot_enc
  import onehot_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IW       = clog2(N)
) (
  input  logic [N-1:0]  sel_i,
  output logic [IW-1:0] index_o,
  output logic          onehot_ok_o
);

  // OR-reduction encoder: exact for legal one-hot input, don't-care otherwise
  // because illegal selects never load the output.
  always_comb begin
    index_o = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel_i[k]) begin
        index_o = index_o | (MSB_FIRST ? IW'(int'(N) - 1 - k) : IW'(k));
      end
    end
  end

  // Non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    onehot_ok_o = (sel_i != '0) && ((sel_i & (sel_i - 1'b1)) == '0);
  end

endmodule

// File: rtl/onehot_mux_reg.sv
// Registered one-hot multiplexer with valid/ready handshake and error tracking.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data, sel        : N channels of W bits, one-hot channel select
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   out_data, out_index : selected channel data and its encoded index
//   out_valid/out_ready : output handshake, single register stage
//   err_clr             : synchronous clear of the error status
//   err_sticky          : set by any rejected (zero or multi-hot) select
//   err_count           : saturating count of rejected selects
module onehot_mux_reg
  import onehot_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 1,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IW       = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_data,
  output logic [IW-1:0]        out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  out_state_e           state_q, state_d;
  logic [W-1:0]         data_q, data_d;
  logic [IW-1:0]        index_q, index_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [ERR_CNT_W-1:0] err_base;

  logic [IW-1:0] enc_index;
  logic          onehot_ok;
  logic [W-1:0]  mux_data;
  logic          in_xfer, out_xfer, good_xfer, bad_xfer;

  onehot_enc #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .sel_i       (sel),
    .index_o     (enc_index),
    .onehot_ok_o (onehot_ok)
  );

  // AND-OR mux keyed directly on the physical select bit.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel[k]) mux_data = mux_data | in_data[k*W +: W];
    end
  end

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign good_xfer = in_xfer && onehot_ok;
  assign bad_xfer  = in_xfer && !onehot_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a rejected beat never refills the register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (good_xfer) state_d = FULL;
      FULL: begin
        if (good_xfer)     state_d = FULL;
        else if (out_xfer) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = !out_valid || out_ready;
  end

  always_comb begin
    data_d  = data_q;
    index_d = index_q;
    if (good_xfer) begin
      data_d  = mux_data;
      index_d = enc_index;
    end
  end

  // Clear applies first so a same-cycle rejected beat still registers.
  always_comb begin
    err_base     = err_clr ? '0 : err_count_q;
    err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
    err_count_d  = err_base;
    if (bad_xfer) begin
      err_sticky_d = 1'b1;
      if (err_base != '1) err_count_d = err_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      index_q      <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      data_q       <= data_d;
      index_q      <= index_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_data   = data_q;
  assign out_index  = index_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule
